// File: rtl/bus_arbiter8_pkg.sv
// Types and the rotate-and-find-first priority search for bus_arbiter8.
package bus_arbiter8_pkg;
`include "arb_defs.vh"

    localparam int NREQ = `ARB_NREQ;

    typedef enum logic {
        IDLE  = `ARB_ST_IDLE,
        GRANT = `ARB_ST_GRANT
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Rotate req so ptr lands at bit 0, take the lowest set bit, then add ptr back.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [2:0] ptr);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        pick_t             p;
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        p   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                p.found = 1'b1;
                p.idx   = ptr + 3'(k);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/arb_defs.vh
// Shared arbiter constants: FSM state encodings and requester count.
`ifndef ARB_DEFS_VH
`define ARB_DEFS_VH
`define ARB_ST_IDLE  1'b0
`define ARB_ST_GRANT 1'b1
`define ARB_NREQ     8
`endif

// File: rtl/bus_arbiter8_mux8x1.sv
// 8:1 payload multiplexer for the arbiter output datapath.
module mux8x1 #(
    parameter int N = 32
) (
    input  logic [2:0]   i_sel,
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    input  logic [N-1:0] i_d2,
    input  logic [N-1:0] i_d3,
    input  logic [N-1:0] i_d4,
    input  logic [N-1:0] i_d5,
    input  logic [N-1:0] i_d6,
    input  logic [N-1:0] i_d7,
    output logic [N-1:0] o_y
);
    always_comb begin
        o_y = i_d0;
        case (i_sel)
            3'd0: o_y = i_d0;
            3'd1: o_y = i_d1;
            3'd2: o_y = i_d2;
            3'd3: o_y = i_d3;
            3'd4: o_y = i_d4;
            3'd5: o_y = i_d5;
            3'd6: o_y = i_d6;
            3'd7: o_y = i_d7;
            default: o_y = i_d0;
        endcase
    end
endmodule

// File: rtl/bus_arbiter8.sv
// 8-requester round-robin bus arbiter with registered grant and muxed payload.
// Define ARB_LOCK_EN to let a locked requester hold the bus for back-to-back beats.
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   req,
    input  logic [7:0]   lock,
    input  logic [N-1:0] A0,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    input  logic [N-1:0] A3,
    input  logic [N-1:0] A4,
    input  logic [N-1:0] A5,
    input  logic [N-1:0] A6,
    input  logic [N-1:0] A7,
    input  logic         ready,
    output logic         valid,
    output logic [7:0]   grant,
    output logic [2:0]   select,
    output logic [N-1:0] Y
);
    arb_state_t r_state;
    logic [2:0] r_ptr;
    pick_t      w_pick;
    logic       w_hold;
    logic       w_release;

    assign w_pick = rr_pick(req, r_ptr);

`ifdef ARB_LOCK_EN
    assign w_hold = lock[select] & req[select];
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
    assign w_hold        = 1'b0;
`endif

    // Leave GRANT on an unheld transfer, or when the owner drops req while stalled.
    assign w_release = ready ? ~w_hold : ~req[select];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= 3'd0;
            select  <= 3'd0;
            grant   <= 8'h00;
            valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick.found) begin
                        select  <= w_pick.idx;
                        grant   <= 8'h01 << w_pick.idx;
                        valid   <= 1'b1;
                        r_state <= GRANT;
                    end else begin
                        grant <= 8'h00;
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_ptr   <= select + 3'd1;
                        grant   <= 8'h00;
                        valid   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mux8x1 #(.N(N)) u_mux (
        .i_sel (select),
        .i_d0  (A0),
        .i_d1  (A1),
        .i_d2  (A2),
        .i_d3  (A3),
        .i_d4  (A4),
        .i_d5  (A5),
        .i_d6  (A6),
        .i_d7  (A7),
        .o_y   (Y)
    );
endmodule

// File: tb/tb_bus_arbiter8.sv
// Self-checking bench for bus_arbiter8: directed vector table, rotation sequence, random vs model.
module tb_bus_arbiter8;
    localparam int N = 32;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         ready;
    logic [7:0]   req;
    logic [7:0]   lock;
    logic [N-1:0] Ad [8];
    logic         valid;
    logic [7:0]   grant;
    logic [2:0]   select;
    logic [N-1:0] Y;

    always #5 clk = ~clk;

    bus_arbiter8 #(.N(N)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock),
        .A0(Ad[0]), .A1(Ad[1]), .A2(Ad[2]), .A3(Ad[3]),
        .A4(Ad[4]), .A5(Ad[5]), .A6(Ad[6]), .A7(Ad[7]),
        .ready(ready), .valid(valid), .grant(grant), .select(select), .Y(Y)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level reference: is someone owning the bus, who, and where the search starts.
    int m_busy = 0;
    int m_sel  = 0;
    int m_ptr  = 0;

    task automatic model_step();
        bit found;
        if (reset) begin
            m_busy = 0; m_sel = 0; m_ptr = 0;
        end else if (m_busy == 0) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && req[(m_ptr + k) % 8]) begin
                    found  = 1'b1;
                    m_sel  = (m_ptr + k) % 8;
                    m_busy = 1;
                end
            end
        end else if (ready) begin
            if (!(LOCK_EN && lock[m_sel] && req[m_sel])) begin
                m_busy = 0;
                m_ptr  = (m_sel + 1) % 8;
            end
        end else if (!req[m_sel]) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % 8;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input bit ev, input logic [7:0] eg, input logic [2:0] es);
        n_vec++;
        if (valid !== ev || grant !== eg || select !== es || Y !== Ad[es]) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b grant=%02h select=%0d Y=%08h, want valid=%0b grant=%02h select=%0d Y=%08h",
                     nm, valid, grant, select, Y, ev, eg, es, Ad[es]);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] rq;
        logic [7:0] lk;
        bit         rdy;
        bit         ev;
        logic [7:0] eg;
        logic [2:0] es;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string nm, input bit rst, input logic [7:0] rq, input logic [7:0] lk,
                                input bit rdy, input bit ev, input logic [7:0] eg, input logic [2:0] es);
        vec_t v;
        v.rst = rst; v.rq = rq; v.lk = lk; v.rdy = rdy;
        v.ev = ev; v.eg = eg; v.es = es; v.nm = nm;
        tbl.push_back(v);
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) Ad[i] = 32'h1000_0000 * (i + 1) + 32'h0000_0ABC * i;
        reset = 1'b1; req = 8'h00; lock = 8'h00; ready = 1'b0;

        add("reset_busy_req",  1, 8'hFF, 8'h00, 1, 0, 8'h00, 3'd0);
        add("reset_state",     1, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0);
        add("single_grant",    0, 8'h04, 8'h00, 1, 1, 8'h04, 3'd2);
        add("single_xfer",     0, 8'h04, 8'h00, 1, 0, 8'h00, 3'd2);
        add("ptr3_pick",       0, 8'h0C, 8'h00, 0, 1, 8'h08, 3'd3);
        add("ptr3_stall",      0, 8'h0C, 8'h00, 0, 1, 8'h08, 3'd3);
        add("abandon3",        0, 8'h04, 8'h00, 0, 0, 8'h00, 3'd3);
        add("bp_grant4",       0, 8'h10, 8'h00, 0, 1, 8'h10, 3'd4);
        for (int i = 0; i < 4; i++) add("bp_hold4", 0, 8'h10, 8'h00, 0, 1, 8'h10, 3'd4);
        add("bp_abandon4",     0, 8'h00, 8'h00, 0, 0, 8'h00, 3'd4);
        add("ptr5_pick",       0, 8'h30, 8'h00, 1, 1, 8'h20, 3'd5);
        add("ptr5_xfer",       0, 8'h30, 8'h00, 1, 0, 8'h00, 3'd5);
        add("serve6",          0, 8'h40, 8'h00, 1, 1, 8'h40, 3'd6);
        add("serve6_xfer",     0, 8'h40, 8'h00, 1, 0, 8'h00, 3'd6);
        add("wrap_7",          0, 8'h81, 8'h00, 1, 1, 8'h80, 3'd7);
        add("wrap_7_xfer",     0, 8'h81, 8'h00, 1, 0, 8'h00, 3'd7);
        add("wrap_0",          0, 8'h81, 8'h00, 1, 1, 8'h01, 3'd0);
        add("wrap_0_xfer",     0, 8'h81, 8'h00, 1, 0, 8'h00, 3'd0);
        add("mid_grant5",      0, 8'h20, 8'h00, 0, 1, 8'h20, 3'd5);
        add("reset_mid_grant", 1, 8'h20, 8'h00, 1, 0, 8'h00, 3'd0);
        add("post_reset_ptr0", 0, 8'h03, 8'h00, 0, 1, 8'h01, 3'd0);
        add("abandon0",        0, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0);
        add("lock_grant1",     0, 8'h0A, 8'h02, 1, 1, 8'h02, 3'd1);
`ifdef ARB_LOCK_EN
        add("lock_beat2",      0, 8'h0A, 8'h02, 1, 1, 8'h02, 3'd1);
        add("lock_beat3",      0, 8'h0A, 8'h02, 1, 1, 8'h02, 3'd1);
        add("lock_beat4",      0, 8'h0A, 8'h02, 1, 1, 8'h02, 3'd1);
        add("lock_release",    0, 8'h0A, 8'h00, 1, 0, 8'h00, 3'd1);
        add("lock_next3",      0, 8'h0A, 8'h00, 1, 1, 8'h08, 3'd3);
`else
        add("lock_ignored",    0, 8'h0A, 8'h02, 1, 0, 8'h00, 3'd1);
        add("after_ign_3",     0, 8'h0A, 8'h02, 1, 1, 8'h08, 3'd3);
        add("after_ign_xfer",  0, 8'h0A, 8'h02, 1, 0, 8'h00, 3'd3);
        add("after_ign_1",     0, 8'h0A, 8'h00, 1, 1, 8'h02, 3'd1);
        add("after_ign_xfer1", 0, 8'h0A, 8'h00, 1, 0, 8'h00, 3'd1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; req = tbl[i].rq; lock = tbl[i].lk; ready = tbl[i].rdy;
            tick();
            check(tbl[i].nm, tbl[i].ev, tbl[i].eg, tbl[i].es);
        end

        // Full contention: strict rotation from requester 0, one bubble after each grant.
        reset = 1'b1; req = 8'h00; lock = 8'h00; ready = 1'b1;
        tick();
        reset = 1'b0; req = 8'hFF;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i % 2 == 0) check("rotation_grant", 1'b1, 8'h01 << ((i / 2) % 8), 3'((i / 2) % 8));
            else            check("rotation_bubble", 1'b0, 8'h00, 3'((i / 2) % 8));
        end

        reset = 1'b1; req = 8'h00; lock = 8'h00; ready = 1'b0;
        tick();
        check("rand_reset", 1'b0, 8'h00, 3'd0);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) req = 8'h00;
            else                           req = 8'($urandom);
            if (m_busy != 0 && $urandom_range(0, 7) != 0) req[m_sel] = 1'b1;
            lock  = 8'($urandom);
            ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 8; i++) Ad[i] = $urandom;
            tick();
            check("random", m_busy != 0, (m_busy != 0) ? (8'h01 << m_sel) : 8'h00, 3'(m_sel));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 SHALL have parameter N, default 32, data width of each requester payload.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  8  per-requester request; bit i belongs to requester i.
REQ-005 SHALL have port lock  input  8  per-requester burst-hold request; ignored unless ARB_LOCK_EN is defined.
REQ-006 SHALL have ports A0..A7  input  N each  requester payloads.
REQ-007 SHALL have port ready  input  1  downstream accepts the current beat.
REQ-008 SHALL have port valid  output  1  Y holds a granted beat.
REQ-009 SHALL have port grant  output  8  one-hot grant, zero when idle.
REQ-010 SHALL have port select  output  3  index of the granted requester.
REQ-011 SHALL have port Y  output  N  payload of the requester at select.

Function
REQ-012 SHALL implement two states: IDLE and GRANT.
REQ-013 SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ... ptr+7, wrapping modulo 8.
REQ-014 In IDLE with req != 0, SHALL register the first set req bit in search order into select and grant, assert valid, and enter GRANT on the next edge; request-to-valid latency is 1 cycle.
REQ-015 In IDLE with req == 0, SHALL hold grant=0 and valid=0, and leave select and ptr unchanged.
REQ-016 In GRANT, a transfer occurs on a cycle where valid && ready are both high.
REQ-017 On a transfer without hold (REQ-026), SHALL set ptr=select+1 (3-bit wrap, 7->0), clear grant and valid, and return to IDLE; this gives one idle bubble between grants.
REQ-018 In GRANT, if req[select] falls before a transfer, SHALL abandon the grant: clear valid and grant, set ptr=select+1, and enter IDLE; no beat transfers.
REQ-019 SHALL drive Y = A[select] combinationally at all times; Y is meaningful only when valid=1.
REQ-020 SHALL keep grant one-hot or zero, with grant[select]=1 whenever valid=1.
REQ-021 SHALL ignore changes on non-granted req bits during GRANT; they are considered only at the next IDLE arbitration.
REQ-022 With all eight requesters continuously requesting, SHALL serve them in strict rotation, each once per 8 grants.

Reset
REQ-023 On reset=1 at a clock edge, SHALL set state=IDLE, ptr=0, select=0, grant=0, and valid=0.
REQ-024 Reset SHALL take priority over every other event, including a transfer in the same cycle; an in-flight grant is dropped without transfer.
REQ-025 SHALL assert no output other than Y until the first edge after reset deasserts.

Configuration
REQ-026 With macro ARB_LOCK_EN defined: on a transfer where lock[select]=1 and req[select]=1, SHALL remain in GRANT with grant, select and ptr unchanged and valid held high, giving back-to-back beats; the first transfer with lock[select]=0 releases per REQ-017.
REQ-027 With ARB_LOCK_EN undefined, SHALL keep the lock port, ignore it, and add no lock logic.

Structure
REQ-028 State encodings (IDLE=0, GRANT=1) and the requester count constant 8 SHALL live in a shared include, arb_defs.vh.
REQ-029 SHALL instantiate one mux8x1 (N=N) sub-module for the Y datapath, driven by the registered select.
REQ-030 SHALL implement priority search as a combinational rotate-and-find-first function; no other sub-modules.

Verification
REQ-031 Single request: reset, then req=8'h04, ready=1 -> valid=1, select=2, grant=8'h04 in cycle 1; transfer in cycle 1; IDLE in cycle 2; ptr=3.
REQ-032 Rotation: req=8'hFF held, ready=1 -> grant sequence 01,02,04,...,80,01, each followed by an idle cycle.
REQ-033 Backpressure and abandon: req=8'h10, ready=0 for 5 cycles -> valid stays 1 and Y=A4; drop req[4] -> valid=0 next cycle; ptr=5.
REQ-034 Wrap: ptr=7 (after serving 6), req=8'h81 -> grant 8'h80 first, then 8'h01.
REQ-035 Lock (ARB_LOCK_EN): req=8'h0A, lock=8'h02, ready=1 for 3 cycles, then lock=0 -> 4 consecutive beats from requester 1 with no bubble, then grant 8'h08.
REQ-036 Reset mid-grant: valid=1, select=5, assert reset with ready=1 -> next cycle valid=0, grant=0, select=0, ptr=0, and no transfer is counted.
